// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg: constants shared by the round-robin stream multiplexer
// and its arbiter.
//   MODE_FIXED / MODE_RR : encodings of the 'mode' input.
package stream_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

endpackage : stream_mux_pkg

// File: rtl/stream_mux_rr_arbiter.sv
// rr_arbiter: purely combinational round-robin arbiter.
//   req        : per-channel request vector
//   ptr        : index of the last granted channel (searched last)
//   en         : arbitration enable; no grant is produced while low
//   gnt_onehot : one-hot grant
//   gnt_idx    : binary index of the granted channel (0 when no grant)
//   gnt_any    : a grant exists
module rr_arbiter #(
  parameter  int N_CH = 8,
  localparam int SW   = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [SW-1:0]   ptr,
  input  logic            en,
  output logic [N_CH-1:0] gnt_onehot,
  output logic [SW-1:0]   gnt_idx,
  output logic            gnt_any
);

  // Walk the offsets from farthest to nearest so that the nearest
  // requester after ptr overwrites any earlier hit. Offset N_CH lands
  // on ptr itself, which therefore has the lowest priority.
  always_comb begin
    int k;
    gnt_any    = 1'b0;
    gnt_idx    = '0;
    gnt_onehot = '0;
    k          = 0;
    for (int i = N_CH; i >= 1; i--) begin
      k = (int'(ptr) + i) % N_CH;
      if (req[k]) begin
        gnt_any = 1'b1;
        gnt_idx = SW'(k);
      end
    end
    if (!en) begin
      gnt_any = 1'b0;
      gnt_idx = '0;
    end
    if (gnt_any) begin
      gnt_onehot[gnt_idx] = 1'b1;
    end
  end

endmodule : rr_arbiter

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N_CH-to-1 stream multiplexer with a registered output,
// valid/ready handshaking and two selection modes (fixed select / RR).
//   clk, rst           : clock and synchronous active-high reset
//   in_valid/in_ready  : per-channel handshake (at most one ready high)
//   in_data            : packed channel data, channel k at [k*W +: W]
//   mode, sel          : 0 = use sel, 1 = round-robin
//   out_valid/out_ready: output handshake
//   out_data, out_ch   : registered word and the channel it came from
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter  int N_CH = 8,
  parameter  int W    = 8,
  localparam int SW   = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   in_valid,
  input  logic [N_CH*W-1:0] in_data,
  output logic [N_CH-1:0]   in_ready,
  input  logic              mode,
  input  logic [SW-1:0]     sel,
  output logic              out_valid,
  output logic [W-1:0]      out_data,
  output logic [SW-1:0]     out_ch,
  input  logic              out_ready
);

  logic              out_valid_reg;
  logic [W-1:0]      out_data_reg;
  logic [SW-1:0]     out_ch_reg;
  logic [SW-1:0]     ptr_reg;

  logic              load_en;
  logic [N_CH-1:0]   rr_onehot;
  logic [SW-1:0]     rr_idx;
  logic              rr_any;
  logic [N_CH-1:0]   fixed_onehot;
  logic              fixed_any;
  logic [N_CH-1:0]   gnt_onehot;
  logic [SW-1:0]     gnt_idx;
  logic              gnt_any;
  logic [W-1:0]      masked_data [N_CH];
  logic [W-1:0]      sel_data;

  // The output stage can take a word when empty or being drained now.
  assign load_en = !out_valid_reg || out_ready;

  rr_arbiter #(
    .N_CH (N_CH)
  ) u_arb (
    .req        (in_valid),
    .ptr        (ptr_reg),
    .en         (load_en && (mode == MODE_RR)),
    .gnt_onehot (rr_onehot),
    .gnt_idx    (rr_idx),
    .gnt_any    (rr_any)
  );

  // Fixed-mode decode: only the selected channel may be granted; an
  // out-of-range sel (non power-of-two N_CH) never grants.
  always_comb begin
    fixed_onehot = '0;
    fixed_any    = 1'b0;
    if (load_en && (mode == MODE_FIXED) && (int'(sel) < N_CH)) begin
      if (in_valid[sel]) begin
        fixed_any         = 1'b1;
        fixed_onehot[sel] = 1'b1;
      end
    end
  end

  always_comb begin
    if (mode == MODE_RR) begin
      gnt_onehot = rr_onehot;
      gnt_idx    = rr_idx;
      gnt_any    = rr_any;
    end else begin
      gnt_onehot = fixed_onehot;
      gnt_idx    = sel;
      gnt_any    = fixed_any;
    end
  end

  // Suppress ready in the reset cycle so no producer sees a transfer.
  assign in_ready = rst ? '0 : gnt_onehot;

  // AND-OR data select from the one-hot grant.
  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_mask
      assign masked_data[gi] = in_data[gi*W +: W] & {W{gnt_onehot[gi]}};
    end
  endgenerate

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      sel_data = sel_data | masked_data[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_ch_reg    <= '0;
      ptr_reg       <= SW'(N_CH - 1);
    end else if (load_en) begin
      if (gnt_any) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= sel_data;
        out_ch_reg    <= gnt_idx;
        if (mode == MODE_RR) begin
          ptr_reg <= gnt_idx;
        end
      end else begin
        // Either already empty or just drained: become empty, keep data.
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_ch    = out_ch_reg;

endmodule : stream_mux_rr

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: scoreboard bench for stream_mux_rr (N_CH=8, W=8).
// Expected words are predicted from a behavioural model when stimulus is
// applied and compared when the DUT presents them on the output.
module tb_stream_mux_rr;

  localparam int N_CH = 8;
  localparam int W    = 8;

  typedef struct packed {
    logic [2:0] ch;
    logic [7:0] data;
  } exp_t;

  logic              clk;
  logic              rst;
  logic [N_CH-1:0]   in_valid;
  logic [N_CH*W-1:0] in_data;
  logic [N_CH-1:0]   in_ready;
  logic              mode;
  logic [2:0]        sel;
  logic              out_valid;
  logic [W-1:0]      out_data;
  logic [2:0]        out_ch;
  logic              out_ready;

  int   errors = 0;
  int   checks = 0;

  exp_t sb_q[$];
  int   seen_q[$];

  // Behavioural model of the output register and RR pointer.
  bit         mo_valid;
  logic [7:0] mo_data;
  logic [2:0] mo_ch;
  int         mptr;

  stream_mux_rr #(
    .N_CH (N_CH),
    .W    (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int model_grant(input bit m, input int s, input logic [7:0] v, input int p);
    int k;
    if (!m) begin
      if (s < N_CH && v[s]) return s;
      return -1;
    end
    for (int i = 1; i <= N_CH; i++) begin
      k = (p + i) % N_CH;
      if (v[k]) return k;
    end
    return -1;
  endfunction

  task automatic model_reset();
    mo_valid = 1'b0;
    mo_data  = 8'h00;
    mo_ch    = 3'd0;
    mptr     = N_CH - 1;
    sb_q.delete();
  endtask

  // One clock of stimulus: drive, check at negedge, advance model.
  task automatic cycle(input bit m, input logic [2:0] s, input logic [7:0] v, input bit ordy);
    int         g;
    bit         le;
    logic [7:0] exp_rdy;
    exp_t       e;
    mode      = m;
    sel       = s;
    in_valid  = v;
    out_ready = ordy;
    @(negedge clk);
    le      = !mo_valid || ordy;
    g       = le ? model_grant(m, int'(s), v, mptr) : -1;
    exp_rdy = (g >= 0) ? 8'(1 << g) : 8'h00;
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    check("out_valid", 32'(out_valid), 32'(mo_valid));
    if (mo_valid && !ordy) begin
      check("stall_data", 32'(out_data), 32'(mo_data));
      check("stall_ch", 32'(out_ch), 32'(mo_ch));
    end
    if (mo_valid && ordy) begin
      check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("sb_data", 32'(out_data), 32'(e.data));
        check("sb_ch", 32'(out_ch), 32'(e.ch));
      end
    end
    if (out_valid && ordy) seen_q.push_back(int'(out_ch));
    if (le) begin
      if (g >= 0) begin
        e.ch     = 3'(g);
        e.data   = 8'(8'hA0 + g);
        sb_q.push_back(e);
        mo_valid = 1'b1;
        mo_data  = e.data;
        mo_ch    = e.ch;
        if (m) mptr = g;
      end else begin
        mo_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    mode      = 1'b1;
    in_valid  = 8'hFF;
    out_ready = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_ch", 32'(out_ch), 32'd0);
    model_reset();
  endtask

  task automatic expect_seen(input string tag, input int exp_q[$]);
    check({tag, "_count"}, 32'(seen_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < seen_q.size(); i++) begin
      check(tag, 32'(seen_q[i]), 32'(exp_q[i]));
    end
    seen_q.delete();
  endtask

  initial begin
    int exp_q[$];
    for (int k = 0; k < N_CH; k++) in_data[k*W +: W] = 8'(8'hA0 + k);
    rst       = 1'b1;
    mode      = 1'b0;
    sel       = 3'd0;
    in_valid  = '0;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Fairness sweep, all channels valid.
    seen_q.delete();
    for (int i = 0; i < 10; i++) cycle(1'b1, 3'd0, 8'hFF, 1'b1);
    exp_q = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
    expect_seen("rr_sweep", exp_q);

    // Fixed select on channel 5, then channel 5 drops.
    for (int i = 0; i < 4; i++) cycle(1'b0, 3'd5, 8'hFF, 1'b1);
    for (int i = 0; i < 2; i++) cycle(1'b0, 3'd5, 8'hDF, 1'b1);
    check("fixed_drop_valid", 32'(out_valid), 32'd0);
    check("fixed_drop_ready", 32'(in_ready), 32'd0);
    exp_q = '{1, 5, 5, 5, 5};
    expect_seen("fixed", exp_q);

    // Back-pressure: one load, four stalled cycles, then release.
    cycle(1'b1, 3'd0, 8'hFF, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 3'd0, 8'hFF, 1'b0);
    cycle(1'b1, 3'd0, 8'hFF, 1'b1);
    cycle(1'b1, 3'd0, 8'h00, 1'b1);
    cycle(1'b1, 3'd0, 8'h00, 1'b1);
    exp_q = '{2, 3};
    expect_seen("backpressure", exp_q);

    // Sparse requests starting from ptr = 6.
    cycle(1'b1, 3'd0, 8'h40, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 3'd0, 8'h05, 1'b1);
    cycle(1'b1, 3'd0, 8'h00, 1'b1);
    cycle(1'b1, 3'd0, 8'h00, 1'b1);
    exp_q = '{6, 0, 2, 0};
    expect_seen("sparse", exp_q);

    // Mode switch: RR pointer survives a FIXED interlude.
    do_reset();
    seen_q.delete();
    for (int i = 0; i < 3; i++) cycle(1'b1, 3'd0, 8'hFF, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 3'd7, 8'hFF, 1'b1);
    cycle(1'b1, 3'd0, 8'hFF, 1'b1);
    cycle(1'b1, 3'd0, 8'h00, 1'b1);
    cycle(1'b1, 3'd0, 8'h00, 1'b1);
    exp_q = '{0, 1, 2, 7, 7, 7, 3};
    expect_seen("mode_switch", exp_q);

    // Reset while a word is held under back-pressure.
    cycle(1'b1, 3'd0, 8'hFF, 1'b0);
    cycle(1'b1, 3'd0, 8'hFF, 1'b0);
    check("held_before_rst", 32'(out_valid), 32'd1);
    do_reset();
    seen_q.delete();
    cycle(1'b1, 3'd0, 8'hFF, 1'b1);
    cycle(1'b1, 3'd0, 8'h00, 1'b1);
    cycle(1'b1, 3'd0, 8'h00, 1'b1);
    exp_q = '{0};
    expect_seen("after_rst", exp_q);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_stream_mux_rr

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-channel to 1 stream multiplexer with a registered output, valid/ready handshaking, and two selection modes: fixed select and fair round-robin. It generalises the combinational 2/4/8:1 mux family to any channel count and data width, and adds back-pressure and arbitration. It sits between multiple producer streams and a single consumer, for example a shared bus or FIFO write port.

## Interface
- N_CH, default 8: number of input channels, 2..64.
- W, default 8: data width per channel, at least 1.
- SW, default $clog2(N_CH): select/channel-index width (derived, not overridden).

- clk, input, 1: single clock, rising edge.
- rst, input, 1: reset, synchronous, active-high.
- in_valid, input, N_CH: per-channel valid.
- in_data, input, N_CH*W: packed channel data. Channel k occupies bits [k*W +: W].
- in_ready, output, N_CH: per-channel ready. At most one bit is high per cycle.
- mode, input, 1: 0 = FIXED (use sel), 1 = RR (round-robin).
- sel, input, SW: channel index used in FIXED mode.
- out_valid, output, 1: output register holds a word.
- out_data, output, W: registered data.
- out_ch, output, SW: index of the channel that supplied out_data.
- out_ready, input, 1: consumer accepts the word.

## Operation
- Transfer on input channel k: in_valid[k] && in_ready[k]. Transfer on output: out_valid && out_ready.
- load_en = !out_valid || out_ready. The output stage accepts a new word whenever it is empty or is being drained in the same cycle.
- Grant g (combinational), evaluated only when load_en = 1:
  - FIXED: g = sel if sel < N_CH and in_valid[sel]. Otherwise there is no grant. Other channels are ignored even if valid.
  - RR: g = first k with in_valid[k], searching ptr+1, ptr+2, … modulo N_CH. This includes ptr itself, which is checked last.
- in_ready[g] = 1 only when load_en and a grant exists. All other in_ready bits are 0.
- On a grant: out_data <= in_data[g], out_ch <= g, out_valid <= 1. In RR mode only, ptr <= g.
- With load_en and no grant: out_valid <= 0 if out_ready was high, otherwise it holds. out_data and out_ch hold their values.
- With load_en = 0, all output registers hold. out_data and out_ch must not change while out_valid && !out_ready.
- ptr is not updated in FIXED mode. Switching back to RR resumes from the last RR grant.
- Mode or sel changes take effect on the next grant evaluation. A word already in the output register is unaffected.
- Fairness: in RR mode with all channels valid and out_ready held at 1, grants cycle 0,1,…,N_CH-1,0,…

## Timing
- Reset values: out_valid = 0, out_data = 0, out_ch = 0, ptr = N_CH-1 (so the first RR search starts at channel 0). in_ready = 0 during rst.
- Latency is 1 cycle, from input transfer to out_valid. Throughput is 1 word per cycle with out_ready held at 1.
- in_ready depends combinationally on out_valid, out_ready, in_valid, mode and sel. There is no combinational path from in_data to any output.
- rst asserted mid-stream discards the held word. No transfer is reported in the reset cycle.
- The consumer may drain and the producer may load in the same cycle. In that case the output is replaced with no bubble.

## Structure
- Shared package stream_mux_pkg:
  - mode constants MODE_FIXED = 1'b0 and MODE_RR = 1'b1.
  - a clog2 helper function, if the tool flow requires it.
- One sub-module, rr_arbiter: inputs req[N_CH], ptr[SW] and en; outputs gnt_onehot[N_CH], gnt_idx[SW] and gnt_any. It is purely combinational.
- The top level holds ptr, the output register, the fixed-mode decode and the data select (AND-OR of one-hot with packed data).

## Test plan
- Reset, then N_CH=8, W=8, RR mode, all in_valid=1, in_data[k]=8'hA0+k, out_ready=1 -> out_ch sequence 0..7,0, out_data A0..A7,A0, with no bubbles after the first cycle.
- FIXED mode, sel=5, in_valid=8'hFF -> only in_ready[5] is high and out_data=A5 every cycle. Then in_valid[5]=0 -> out_valid drops the next cycle and in_ready = 0.
- Back-pressure: RR mode, out_ready=0 for 4 cycles after the first load -> out_data and out_ch are stable, in_ready = 0 throughout. Release -> next grant goes to ptr+1.
- Sparse requests: RR mode, ptr=6, in_valid=8'b0000_0101 -> grant 0, then 2, then 0.
- Mode switch: RR grants 0,1,2, then FIXED with sel=7 for 3 words, then back to RR -> the next RR grant is 3.
- Mid-stream rst with out_valid=1 and out_ready=0 -> the next cycle shows out_valid=0, out_data=0 and out_ch=0. The first RR grant after reset is channel 0.
